// File: rtl/apb_master.sv
// APB requester bridge: valid/ready command in, SETUP/ACCESS sequence on APB, one-cycle response out.
// Optional access timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  state_t                  state_q,     state_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic                    pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          if (cmd_write) pwdata_d = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          if (!pwrite_q) rsp_rdata_d = prdata;
        end
`ifdef APB_TIMEOUT_EN
        // Abort on the edge that would bring the stall count to TIMEOUT_CYCLES
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE) && preset;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master with a behavioural register-file APB slave
// that can insert wait states or stall pready indefinitely.
`timescale 1ns/1ps
module tb_apb_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  always #5 pclk = ~pclk;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  // Slave: 32-entry register file decoded on paddr[4:0]
  logic [DW-1:0] mem [32] = '{default: '0};
  int wait_cfg = 0;
  bit stuck    = 1'b0;
  int wcnt     = 0;
  assign pready = psel && penable && !stuck && (wcnt >= wait_cfg);
  assign prdata = mem[paddr[4:0]];
  always @(posedge pclk) begin
    if (psel && penable) begin
      if (pready) begin
        wcnt <= 0;
        if (pwrite) mem[paddr[4:0]] <= pwdata;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_rsp = 0;
  int   last_acc = 0;
  int   last_gap = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: response scoreboard plus APB phase/stability checks
  logic          prev_setup = 1'b0;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          cap_write;
  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding command (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
    if (prev_setup) chk("setup_one_cycle", 64'(penable), 64'd1);
    if (psel === 1'b1 && penable === 1'b0) begin
      cap_addr  = paddr;
      cap_wdata = pwdata;
      cap_write = pwrite;
    end else if (psel === 1'b1 && penable === 1'b1) begin
      chk("access_paddr_stable", 64'(paddr), 64'(cap_addr));
      chk("access_pwdata_stable", 64'(pwdata), 64'(cap_wdata));
      chk("access_pwrite_stable", 64'(pwrite), 64'(cap_write));
    end
    prev_setup = (psel === 1'b1) && (penable === 1'b0);
  end

  // Present a command, record expectation at the accepting edge, return 1ns after it
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit track, input logic [DW-1:0] er, input bit ee, input int lat);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    do begin
      @(negedge pclk);
      n++;
    end while (cmd_ready !== 1'b1 && n < 200);
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b expected 1 within 200 cycles", cmd_ready);
    end else begin
      last_gap = cyc - last_acc;
      last_acc = cyc;
      if (track) sb.push_back('{er, ee, lat, cyc});
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    cmd_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge pclk);
      n++;
    end
    chk("rsp_drain", 64'(sb.size()), 64'd0);
    @(posedge pclk);
    #1;
  endtask

  int n0;

  initial begin
    preset    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h4;
    cmd_wdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(posedge pclk);
      #1;
      chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    chk("reset_psel", 64'(psel), 64'd0);
    chk("reset_penable", 64'(penable), 64'd0);
    chk("reset_pwrite", 64'(pwrite), 64'd0);
    chk("reset_paddr", 64'(paddr), 64'd0);
    chk("reset_pwdata", 64'(pwdata), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);

    cmd_valid = 1'b0;
    preset    = 1'b1;
    #1;
    chk("release_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (2) begin
      @(posedge pclk);
      #1;
      chk("idle_no_psel", 64'(psel), 64'd0);
    end

    // Zero-wait write then read back
    issue(1'b1, 32'h04, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 3);
    wait_rsp();
    issue(1'b0, 32'h04, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
    wait_rsp();
    chk("read_keeps_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    chk("idle_keeps_paddr", 64'(paddr), 64'h04);

    // Four wait states per access
    wait_cfg = 4;
    issue(1'b1, 32'h08, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0, 7);
    wait_rsp();
    issue(1'b0, 32'h08, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 7);
    wait_rsp();
    wait_cfg = 0;

    // Back-to-back with cmd_valid held
    issue(1'b1, 32'h01, 32'hA5A5_A5A5, 1'b1, 32'h1234_5678, 1'b0, 3);
    issue(1'b1, 32'h02, 32'h5A5A_5A5A, 1'b1, 32'h1234_5678, 1'b0, 3);
    chk("b2b_write_gap", 64'(last_gap), 64'd3);
    wait_rsp();
    issue(1'b0, 32'h01, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b0, 3);
    issue(1'b0, 32'h02, 32'h0, 1'b1, 32'h5A5A_5A5A, 1'b0, 3);
    chk("b2b_read_gap", 64'(last_gap), 64'd3);
    wait_rsp();
    issue(1'b0, 32'h1F, 32'h0, 1'b1, 32'h0, 1'b0, 3);
    wait_rsp();

    // Stalled slave
    stuck = 1'b1;
`ifdef APB_TIMEOUT_EN
    issue(1'b0, 32'h04, 32'h0, 1'b1, 32'h0, 1'b1, 2 + TO);
    wait_rsp();
    chk("timeout_psel_low", 64'(psel), 64'd0);
    issue(1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge pclk);
      #1;
    end
`else
    n0 = n_rsp;
    issue(1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    cmd_valid = 1'b0;
    repeat (100) @(posedge pclk);
    #1;
    chk("no_timeout_no_rsp", 64'(n_rsp), 64'(n0));
`endif
    chk("stall_in_access", 64'({psel, penable}), 64'b11);

    // Reset in ACCESS drops the transfer
    n0 = n_rsp;
    preset = 1'b0;
    @(posedge pclk);
    #1;
    chk("midreset_psel", 64'(psel), 64'd0);
    chk("midreset_penable", 64'(penable), 64'd0);
    chk("midreset_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(posedge pclk);
    #1;
    chk("midreset_no_rsp", 64'(n_rsp), 64'(n0));
    stuck  = 1'b0;
    preset = 1'b1;

    // Recovery after reset
    issue(1'b1, 32'h0A, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 3);
    wait_rsp();
    issue(1'b0, 32'h0A, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 3);
    wait_rsp();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
